// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: FSM states,
// opcodes, datapath select codes and the bundled control-strobe struct.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_REG     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/mcu_wait_timer.sv
// Counts consecutive not-ready cycles of a memory wait state and flags when
// the configured timeout is reached (MEM_TIMEOUT = 0 never expires).
module mcu_wait_timer #(
    parameter int TMR_W       = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    logic [TMR_W-1:0] cnt;

    // Saturate so a disabled timeout cannot wrap back through small values.
    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (tick && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

    assign expired = (MEM_TIMEOUT != 0) && (cnt == TMR_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the MIPS-subset datapath with memory handshake,
// bus timeout, halt and illegal-opcode flag. MULTICYCLE_PERF_CNT_EN adds perf counters.
module multicycle_controller
    import multicycle_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TMR_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       halt,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       halted,
    output logic       illegal_op,
    output logic       bus_err
`ifdef MULTICYCLE_PERF_CNT_EN
   ,output logic [31:0] cycle_count,
    output logic [31:0] instr_retired
`endif
);

    state_t st, nxt, dec;
    ctrl_t  c;
    logic   in_wait;
    logic   tmr_clear, tmr_tick, tmr_expired;

    // The branch decision is made in the datapath; zero only passes by here.
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk) begin
        if (reset)
            st <= S_FETCH;
        else
            st <= nxt;
    end

    always_comb begin
        c          = '0;
        nxt        = st;
        in_wait    = 1'b0;
        halted     = 1'b0;
        illegal_op = 1'b0;
        bus_err    = 1'b0;
        // Selects show the FETCH decode while reset is held.
        dec        = reset ? S_FETCH : st;

        case (dec)
            S_FETCH: begin
                c.mem_read  = ~halt;
                c.alu_src_b = ALUSRCB_FOUR;
                c.alu_op    = ALU_OP_ADD;
                c.pc_source = PCSRC_ALU;
                if (halt) begin
                    halted = 1'b1;
                end else begin
                    in_wait = 1'b1;
                    if (mem_ready) begin
                        c.ir_write = 1'b1;
                        c.pc_write = 1'b1;
                        nxt        = S_DECODE;
                    end else if (tmr_expired) begin
                        bus_err = 1'b1;
                        nxt     = S_FETCH;
                    end
                end
            end
            S_DECODE: begin
                c.alu_src_b = ALUSRCB_IMM_SH2;
                c.alu_op    = ALU_OP_ADD;
                case (opcode)
                    OP_LW, OP_SW: nxt = S_MEM_ADDR;
                    OP_RTYPE:     nxt = S_EXECUTE;
                    OP_ADDI:      nxt = S_ADDI_EXEC;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_J:         nxt = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        nxt        = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUSRCB_IMM;
                nxt = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
                in_wait    = 1'b1;
                if (mem_ready) begin
                    nxt = S_MEM_WB;
                end else if (tmr_expired) begin
                    bus_err = 1'b1;
                    nxt     = S_FETCH;
                end
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                nxt          = S_FETCH;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
                in_wait     = 1'b1;
                if (mem_ready) begin
                    nxt = S_FETCH;
                end else if (tmr_expired) begin
                    bus_err = 1'b1;
                    nxt     = S_FETCH;
                end
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUSRCB_REG;
                c.alu_op    = ALU_OP_FUNCT;
                nxt         = S_ALU_WB;
            end
            S_ALU_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                nxt         = S_FETCH;
            end
            S_ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUSRCB_IMM;
                nxt         = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                c.reg_write = 1'b1;
                nxt         = S_FETCH;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = ALUSRCB_REG;
                c.alu_op        = ALU_OP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
                nxt             = S_FETCH;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
                nxt         = S_FETCH;
            end
            default: nxt = S_FETCH;
        endcase

        if (reset) begin
            c.pc_write      = 1'b0;
            c.pc_write_cond = 1'b0;
            c.ir_write      = 1'b0;
            c.mem_read      = 1'b0;
            c.mem_write     = 1'b0;
            c.reg_write     = 1'b0;
            halted          = 1'b0;
            illegal_op      = 1'b0;
            bus_err         = 1'b0;
        end
    end

    // A timeout in FETCH or a halted FETCH keeps the state, so clear explicitly.
    assign tmr_clear = (nxt != st) | bus_err | halted;
    assign tmr_tick  = in_wait & ~mem_ready;

    mcu_wait_timer #(
        .TMR_W      (TMR_W),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .tick   (tmr_tick),
        .expired(tmr_expired)
    );

    assign pc_write      = c.pc_write;
    assign pc_write_cond = c.pc_write_cond;
    assign ir_write      = c.ir_write;
    assign iord          = c.iord;
    assign mem_read      = c.mem_read;
    assign mem_write     = c.mem_write;
    assign mem_to_reg    = c.mem_to_reg;
    assign reg_dst       = c.reg_dst;
    assign reg_write     = c.reg_write;
    assign alu_src_a     = c.alu_src_a;
    assign alu_src_b     = c.alu_src_b;
    assign alu_op        = c.alu_op;
    assign pc_source     = c.pc_source;
    assign state         = st;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic retire;
    assign retire = ~reset & ((st == S_MEM_WB) | (st == S_ALU_WB) | (st == S_ADDI_WB) |
                              (st == S_BRANCH) | (st == S_JUMP) |
                              ((st == S_MEM_WRITE) & mem_ready));

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count   <= '0;
            instr_retired <= '0;
        end else begin
            if (!halted)
                cycle_count <= cycle_count + 32'd1;
            if (retire)
                instr_retired <= instr_retired + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction-path reference model checked every
// cycle, plus directed vectors with literal expectations (MEM_TIMEOUT = 4).
module tb_multicycle_controller;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready, halt;
    logic [5:0] opcode;
    logic       pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic       halted, illegal_op, bus_err;
`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_count, instr_retired;
    int unsigned m_cyc = 0, m_ret = 0;
    logic [31:0] snap;
`endif

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_TIMEOUT(TO), .TMR_W(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .halt(halt),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .halted(halted),
        .illegal_op(illegal_op), .bus_err(bus_err)
`ifdef MULTICYCLE_PERF_CNT_EN
       ,.cycle_count(cycle_count), .instr_retired(instr_retired)
`endif
    );

    int checks = 0, errors = 0;
    int ms = 0, mw = 0;
    bit cmp_en = 0;

    // State sequence each opcode walks; the end of a path returns to FETCH.
    function automatic int path_next(int s, logic [5:0] op);
        int p[6];
        case (op)
            6'b100011: p = '{0, 1, 2, 3, 4, -1};
            6'b101011: p = '{0, 1, 2, 5, -1, -1};
            6'b000000: p = '{0, 1, 6, 7, -1, -1};
            6'b001000: p = '{0, 1, 10, 11, -1, -1};
            6'b000100: p = '{0, 1, 8, -1, -1, -1};
            6'b000010: p = '{0, 1, 9, -1, -1, -1};
            default:   p = '{0, 1, -1, -1, -1, -1};
        endcase
        for (int i = 0; i < 5; i++)
            if (p[i] == s && p[i+1] >= 0) return p[i+1];
        return 0;
    endfunction

    function automatic bit is_wait(int s, logic h);
        return (s == 0 && !h) || s == 3 || s == 5;
    endfunction

    function automatic bit known_op(logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b001000 || op == 6'b000100 || op == 6'b000010;
    endfunction

    // {pc_write,pc_write_cond,ir_write,iord,mem_read,mem_write,mem_to_reg,reg_dst,
    //  reg_write,alu_src_a,alu_src_b,alu_op,pc_source,halted,illegal_op,bus_err}
    function automatic logic [18:0] exp_calc(int s, logic r, logic h, logic [5:0] op,
                                             int w, logic rst);
        logic pw, pwc, irw, io, mr, mwr, m2r, rd, rw, asa, hl, ill, be;
        logic [1:0] asb, aop, psrc;
        int s2;
        s2 = rst ? 0 : s;
        {pw, pwc, irw, io, mr, mwr, m2r, rd, rw, asa, hl, ill, be} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (s2)
            0:  begin mr = !h; irw = r && !h; pw = r && !h; asb = 2'b01; hl = h; end
            1:  begin asb = 2'b11; ill = !known_op(op); end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; io = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            9:  begin pw = 1; psrc = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: begin rw = 1; end
            default: ;
        endcase
        be = is_wait(s2, h) && !r && TO != 0 && w == TO;
        if (rst) {pw, pwc, irw, mr, mwr, rw, hl, ill, be} = '0;
        return {pw, pwc, irw, io, mr, mwr, m2r, rd, rw, asa, asb, aop, psrc, hl, ill, be};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            ms <= 0; mw <= 0;
        end else if (ms == 0 && halt) begin
            mw <= 0;
        end else if (is_wait(ms, halt) && !mem_ready) begin
            if (TO != 0 && mw == TO) begin ms <= 0; mw <= 0; end
            else mw <= mw + 1;
        end else begin
            ms <= path_next(ms, opcode); mw <= 0;
        end
`ifdef MULTICYCLE_PERF_CNT_EN
        if (reset) begin
            m_cyc <= 0; m_ret <= 0;
        end else begin
            if (!(ms == 0 && halt)) m_cyc <= m_cyc + 1;
            if (ms == 4 || ms == 7 || ms == 11 || ms == 8 || ms == 9 || (ms == 5 && mem_ready))
                m_ret <= m_ret + 1;
        end
`endif
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [18:0] act, ex;
            act = {pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, mem_to_reg,
                   reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                   halted, illegal_op, bus_err};
            ex = exp_calc(ms, mem_ready, halt, opcode, mw, reset);
            checks++;
            if (act !== ex || state !== 4'(ms)) begin
                errors++;
                $display("FAIL model_cmp t=%0t state=%0d outs=%b required state=%0d outs=%b",
                         $time, state, act, ms, ex);
            end
`ifdef MULTICYCLE_PERF_CNT_EN
            checks++;
            if (cycle_count !== m_cyc || instr_retired !== m_ret) begin
                errors++;
                $display("FAIL perf_cmp t=%0t cyc=%0d ret=%0d required cyc=%0d ret=%0d",
                         $time, cycle_count, instr_retired, m_cyc, m_ret);
            end
`endif
        end
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", nm, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1; mem_ready = 1; halt = 0; zero = 0; opcode = 6'b000000;
        step(); cmp_en = 1;
        step(); reset = 0;
        @(negedge clk);
        chk("rst_state", 32'(state), 0);
        chk("first_mem_read", 32'(mem_read), 1);
        // R-type up to EXECUTE, then reset for 3 cycles
        step(); @(negedge clk); chk("r_decode", 32'(state), 1);
        step(); reset = 1; @(negedge clk);
        chk("rst_in_exec_state", 32'(state), 6);
        chk("rst_strobes", 32'({pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write}), 0);
        chk("rst_srcb_fetch", 32'(alu_src_b), 1);
        chk("rst_aluop_fetch", 32'(alu_op), 0);
        step(); @(negedge clk); chk("rst_to_fetch", 32'(state), 0);
        step(); step(); reset = 0; @(negedge clk); chk("post_rst_fetch", 32'(state), 0);

        // lw: 0,1,2,3,4 then fetch on cycle 6
        begin
            int exp_s[5] = '{1, 2, 3, 4, 0};
            for (int i = 0; i < 5; i++) begin
                step(); if (i == 0) opcode = 6'b100011;
                @(negedge clk);
                chk("lw_state", 32'(state), 32'(exp_s[i]));
                if (i == 3) chk("lw_wb", 32'({reg_write, mem_to_reg, reg_dst}), 32'b110);
            end
        end

        // beq: 0,1,8
        step(); opcode = 6'b000100; @(negedge clk); chk("beq_decode", 32'(state), 1);
        step(); @(negedge clk);
        chk("beq_state", 32'(state), 8);
        chk("beq_outs", 32'({pc_write_cond, alu_op, pc_source, pc_write}), 32'b1_01_01_0);
        step(); @(negedge clk); chk("beq_done", 32'(state), 0);

        // sw with memory never ready: bus_err on 5th wait cycle
        step(); opcode = 6'b101011;
        step(); @(negedge clk); chk("sw_addr", 32'(state), 2);
        step(); mem_ready = 0;
        for (int w = 0; w < 5; w++) begin
            @(negedge clk);
            chk("sw_wait_state", 32'(state), 5);
            chk("sw_bus_err", 32'(bus_err), (w == 4) ? 1 : 0);
            chk("sw_no_regw", 32'(reg_write), 0);
            if (w < 4) step();
        end
        step(); mem_ready = 1; @(negedge clk);
        chk("sw_abort_fetch", 32'(state), 0);
        chk("sw_err_once", 32'(bus_err), 0);

        // illegal opcode
        step(); opcode = 6'b111111; @(negedge clk);
        chk("ill_state", 32'(state), 1);
        chk("ill_flag", 32'(illegal_op), 1);
        step(); @(negedge clk);
        chk("ill_back", 32'(state), 0);
        chk("ill_clear", 32'(illegal_op), 0);

        // lw where ready arrives on the timeout cycle: ready wins
        step(); opcode = 6'b100011;
        step(); step(); mem_ready = 0;
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            chk("rdy_wait_state", 32'(state), 3);
            step();
        end
        mem_ready = 1; @(negedge clk);
        chk("rdy_wins_state", 32'(state), 3);
        chk("rdy_wins_no_err", 32'(bus_err), 0);
        step(); @(negedge clk); chk("rdy_wins_wb", 32'(state), 4);

        // fetch that never gets memory: bus_err on 5th cycle, no ir_write
        step(); mem_ready = 0;
        for (int w = 0; w < 5; w++) begin
            @(negedge clk);
            chk("fto_state", 32'(state), 0);
            chk("fto_bus_err", 32'(bus_err), (w == 4) ? 1 : 0);
            chk("fto_ir_write", 32'(ir_write), 0);
            if (w < 4) step();
        end
        step(); mem_ready = 1; @(negedge clk);
        chk("fto_retry", 32'({ir_write, pc_write, bus_err}), 32'b110);

        // halt raised during EXECUTE of an R-type
        step(); opcode = 6'b000000;
        step(); halt = 1; @(negedge clk); chk("halt_exec", 32'(state), 6);
`ifdef MULTICYCLE_PERF_CNT_EN
        snap = instr_retired;
`endif
        step(); @(negedge clk);
        chk("halt_alu_wb", 32'({state, reg_write, reg_dst}), 32'({4'd7, 2'b11}));
        step(); @(negedge clk);
        chk("halt_park", 32'({state, halted, mem_read, ir_write}), 32'({4'd0, 3'b100}));
`ifdef MULTICYCLE_PERF_CNT_EN
        chk("halt_retired", instr_retired, snap + 1);
        snap = cycle_count;
`endif
        step(); step(); @(negedge clk);
        chk("halt_hold", 32'({state, halted}), 32'({4'd0, 1'b1}));
`ifdef MULTICYCLE_PERF_CNT_EN
        chk("halt_cyc_frozen", cycle_count, snap);
`endif
        step(); halt = 0; @(negedge clk);
        chk("halt_release", 32'({halted, ir_write}), 32'b01);

        // j then addi
        step(); opcode = 6'b000010;
        step(); @(negedge clk);
        chk("j_outs", 32'({state, pc_write, pc_source}), 32'({4'd9, 1'b1, 2'b10}));
        step(); step(); opcode = 6'b001000;
        step(); @(negedge clk); chk("addi_exec", 32'({state, alu_src_a, alu_src_b}), 32'({4'd10, 3'b110}));
        step(); @(negedge clk);
        chk("addi_wb", 32'({state, reg_write, reg_dst, mem_to_reg}), 32'({4'd11, 3'b100}));
        step(); @(negedge clk); chk("addi_done", 32'(state), 0);

        step();
        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
